// File: rtl/rggen_bit_field_wfifo_pkg.sv
// Shared helpers for the write-FIFO bit field and its pointer/count controller.
package rggen_bit_field_wfifo_pkg;

    // Pointer width for a DEPTH-entry ring; never below one bit.
    function automatic int ptr_width(int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/rggen_bit_field_wfifo_if.sv
// Software-side bit-field access bundle between the register block and a bit field.
interface rggen_bit_field_if #(
    parameter int WIDTH = 8
);
    logic             valid;
    logic [WIDTH-1:0] read_mask;
    logic [WIDTH-1:0] write_mask;
    logic [WIDTH-1:0] write_data;
    logic [WIDTH-1:0] read_data;
    logic [WIDTH-1:0] value;

    modport master (
        output valid,
        output read_mask,
        output write_mask,
        output write_data,
        input  read_data,
        input  value
    );

    modport bit_field (
        input  valid,
        input  read_mask,
        input  write_mask,
        input  write_data,
        output read_data,
        output value
    );
endinterface

// File: rtl/rggen_bit_field_wfifo_ctrl.sv
// Pointer, occupancy and overflow bookkeeping for a DEPTH-entry ring buffer.
module rggen_fifo_ctrl
    import rggen_bit_field_wfifo_pkg::*;
#(
    parameter int  DEPTH      = 4,
    localparam int PtrWidth   = ptr_width(DEPTH),
    localparam int CountWidth = $clog2(DEPTH + 1)
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_clear,
    input  logic                  i_push,
    input  logic                  i_pop,
    output logic                  o_push_accept,
    output logic [PtrWidth-1:0]   o_wptr,
    output logic [PtrWidth-1:0]   o_rptr,
    output logic [CountWidth-1:0] o_count,
    output logic                  o_full,
    output logic                  o_empty,
    output logic                  o_overflow
);

    logic [PtrWidth-1:0]   wptr_q;
    logic [PtrWidth-1:0]   rptr_q;
    logic [CountWidth-1:0] count_q;
    logic                  overflow_q;
    logic                  pop_eff;

    function automatic logic [PtrWidth-1:0] ptr_next(logic [PtrWidth-1:0] ptr);
        return (ptr == PtrWidth'(DEPTH - 1)) ? '0 : ptr + PtrWidth'(1);
    endfunction

    always_comb begin
        o_full        = (count_q == CountWidth'(DEPTH));
        o_empty       = (count_q == '0);
        pop_eff       = i_pop & ~o_empty & ~i_clear;
        // A full FIFO still takes a push when the head leaves on the same edge.
        o_push_accept = i_push & ~i_clear & (~o_full | pop_eff);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else if (i_clear) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (o_push_accept) begin
                wptr_q <= ptr_next(wptr_q);
            end
            if (pop_eff) begin
                rptr_q <= ptr_next(rptr_q);
            end
            unique case ({o_push_accept, pop_eff})
                2'b10:   count_q <= count_q + CountWidth'(1);
                2'b01:   count_q <= count_q - CountWidth'(1);
                default: count_q <= count_q;
            endcase
            overflow_q <= i_push & ~o_push_accept;
        end
    end

    assign o_wptr     = wptr_q;
    assign o_rptr     = rptr_q;
    assign o_count    = count_q;
    assign o_overflow = overflow_q;

endmodule

// File: rtl/rggen_bit_field_wfifo.sv
// Write-FIFO bit field: software writes enqueue masked data, hardware drains the head.
module rggen_bit_field_wfifo
    import rggen_bit_field_wfifo_pkg::*;
#(
    parameter int  WIDTH      = 8,
    parameter int  DEPTH      = 4,
    localparam int CountWidth = $clog2(DEPTH + 1)
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    rggen_bit_field_if.bit_field  bit_field_if,
    input  logic                  i_clear,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [WIDTH-1:0]      o_data,
    output logic [CountWidth-1:0] o_count,
    output logic                  o_full,
    output logic                  o_empty,
    output logic                  o_overflow
);

    localparam int PtrWidth = ptr_width(DEPTH);

    logic [WIDTH-1:0]    mem [DEPTH];
    logic [PtrWidth-1:0] wptr;
    logic [PtrWidth-1:0] rptr;
    logic                push;
    logic                pop;
    logic                push_accept;
    logic [WIDTH-1:0]    push_data;
    logic                unused_read_mask;

    assign push             = bit_field_if.valid & (|bit_field_if.write_mask);
    assign push_data        = bit_field_if.write_data & bit_field_if.write_mask;
    assign pop              = o_valid & i_ready;
    assign unused_read_mask = ^bit_field_if.read_mask;

    rggen_fifo_ctrl #(
        .DEPTH (DEPTH)
    ) u_ctrl (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_clear       (i_clear),
        .i_push        (push),
        .i_pop         (pop),
        .o_push_accept (push_accept),
        .o_wptr        (wptr),
        .o_rptr        (rptr),
        .o_count       (o_count),
        .o_full        (o_full),
        .o_empty       (o_empty),
        .o_overflow    (o_overflow)
    );

    // Storage is left unreset; the empty mask on o_data hides stale entries.
    always_ff @(posedge i_clk) begin
        if (push_accept) begin
            mem[wptr] <= push_data;
        end
    end

    assign o_valid                = ~o_empty;
    assign o_data                 = o_empty ? '0 : mem[rptr];
    assign bit_field_if.read_data = o_data;
    assign bit_field_if.value     = o_data;

endmodule

// File: tb/tb_rggen_bit_field_wfifo.sv
// Directed scoreboard bench for rggen_bit_field_wfifo (WIDTH=8, DEPTH=4).
module tb_rggen_bit_field_wfifo;

    logic       i_clk = 1'b0;
    logic       i_rst_n = 1'b0;
    logic       i_clear = 1'b0;
    logic       i_ready = 1'b0;
    logic       o_valid;
    logic [7:0] o_data;
    logic [2:0] o_count;
    logic       o_full;
    logic       o_empty;
    logic       o_overflow;

    int         nvec = 0;
    int         nmis = 0;
    logic [7:0] sb[$];

    rggen_bit_field_if #(.WIDTH(8)) bif ();

    rggen_bit_field_wfifo #(
        .WIDTH (8),
        .DEPTH (4)
    ) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .bit_field_if (bif.bit_field),
        .i_clear      (i_clear),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_data       (o_data),
        .o_count      (o_count),
        .o_full       (o_full),
        .o_empty      (o_empty),
        .o_overflow   (o_overflow)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every pop the DUT performs must deliver the scoreboard head.
    always @(negedge i_clk) begin
        if (i_rst_n && !i_clear && o_valid && i_ready) begin
            if (sb.size() == 0) begin
                nvec++;
                nmis++;
                $display("FAIL pop_unexpected: got %0h expected none", o_data);
            end else begin
                check("pop_data", o_data, sb.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic write(input logic [7:0] data, input logic [7:0] mask);
        bif.valid      = 1'b1;
        bif.write_data = data;
        bif.write_mask = mask;
        tick();
        bif.valid      = 1'b0;
        bif.write_mask = 8'h00;
    endtask

    task automatic drain(input int n);
        i_ready = 1'b1;
        repeat (n) tick();
        i_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bif.valid      = 1'b0;
        bif.read_mask  = 8'h00;
        bif.write_mask = 8'h00;
        bif.write_data = 8'h00;
        repeat (2) tick();
        check("rst_count", 8'(o_count), 8'd0);
        check("rst_empty", 8'(o_empty), 8'd1);
        check("rst_full", 8'(o_full), 8'd0);
        check("rst_valid", 8'(o_valid), 8'd0);
        check("rst_data", o_data, 8'h00);
        check("rst_ovf", 8'(o_overflow), 8'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        tick();

        // Single write, then a masked write, then a read-only access.
        sb.push_back(8'hA5);
        write(8'hA5, 8'hFF);
        check("w1_valid", 8'(o_valid), 8'd1);
        check("w1_data", o_data, 8'hA5);
        check("w1_count", 8'(o_count), 8'd1);
        sb.push_back(8'h0C);
        write(8'h3C, 8'h0F);
        check("w2_count", 8'(o_count), 8'd2);
        bif.read_mask = 8'hFF;
        write(8'hFF, 8'h00);
        bif.read_mask = 8'h00;
        check("rd_count", 8'(o_count), 8'd2);
        check("rd_data", bif.read_data, 8'hA5);
        check("rd_value", bif.value, 8'hA5);
        drain(2);
        check("drain1_empty", 8'(o_empty), 8'd1);
        check("drain1_data", o_data, 8'h00);

        // Fill to full, then one dropped write.
        sb.push_back(8'h11);
        write(8'h11, 8'hFF);
        sb.push_back(8'h22);
        write(8'h22, 8'hFF);
        sb.push_back(8'h33);
        write(8'h33, 8'hFF);
        check("ovf_before", 8'(o_overflow), 8'd0);
        sb.push_back(8'h44);
        write(8'h44, 8'hFF);
        check("full_flag", 8'(o_full), 8'd1);
        check("full_count", 8'(o_count), 8'd4);
        write(8'h55, 8'hFF);
        check("ovf_pulse", 8'(o_overflow), 8'd1);
        check("ovf_count", 8'(o_count), 8'd4);
        check("ovf_head", o_data, 8'h11);
        tick();
        check("ovf_end", 8'(o_overflow), 8'd0);

        // Push and pop together while full.
        sb.push_back(8'h66);
        i_ready = 1'b1;
        write(8'h66, 8'hFF);
        i_ready = 1'b0;
        check("pp_count", 8'(o_count), 8'd4);
        check("pp_full", 8'(o_full), 8'd1);
        check("pp_ovf", 8'(o_overflow), 8'd0);
        check("pp_head", o_data, 8'h22);
        drain(4);
        check("drain2_empty", 8'(o_empty), 8'd1);

        // Clear with a simultaneous push.
        write(8'h01, 8'hFF);
        write(8'h02, 8'hFF);
        write(8'h03, 8'hFF);
        check("clr_pre_count", 8'(o_count), 8'd3);
        i_clear = 1'b1;
        write(8'h77, 8'hFF);
        i_clear = 1'b0;
        check("clr_count", 8'(o_count), 8'd0);
        check("clr_empty", 8'(o_empty), 8'd1);
        check("clr_data", o_data, 8'h00);
        check("clr_ovf", 8'(o_overflow), 8'd0);
        tick();
        check("clr_ovf2", 8'(o_overflow), 8'd0);

        // Asynchronous reset mid-stream.
        sb.push_back(8'hB1);
        write(8'hB1, 8'hFF);
        sb.push_back(8'hB2);
        write(8'hB2, 8'hFF);
        check("mr_pre_count", 8'(o_count), 8'd2);
        #1;
        i_rst_n = 1'b0;
        sb.delete();
        #1;
        check("mr_count", 8'(o_count), 8'd0);
        check("mr_empty", 8'(o_empty), 8'd1);
        check("mr_valid", 8'(o_valid), 8'd0);
        check("mr_data", o_data, 8'h00);
        tick();
        @(negedge i_clk);
        i_rst_n = 1'b1;
        sb.push_back(8'h5A);
        write(8'h5A, 8'hFF);
        check("post_valid", 8'(o_valid), 8'd1);
        check("post_data", o_data, 8'h5A);
        check("post_count", 8'(o_count), 8'd1);
        drain(1);
        check("sb_empty", 8'(sb.size()), 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

// File: doc/rggen_bit_field_wfifo.md
RGGEN_BIT_FIELD_WFIFO -- requirements
Module: rggen_bit_field_wfifo

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning bit-field and FIFO entry width (1..64).
REQ-002 SHALL have parameter DEPTH, default 4, meaning FIFO entries (>=2, power of two not required).
REQ-003 SHALL have port i_clk  input  1  clock; one clock domain, all state on its rising edge.
REQ-004 SHALL have port i_rst_n  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port bit_field_if  rggen_bit_field_if.bit_field  WIDTH  software-side access (valid, read_mask, write_mask, write_data, read_data, value).
REQ-006 SHALL have port i_clear  input  1  synchronous flush request from hardware.
REQ-007 SHALL have port o_valid  output  1  head entry available to hardware.
REQ-008 SHALL have port i_ready  input  1  hardware accepts head entry.
REQ-009 SHALL have port o_data  output  WIDTH  head entry data.
REQ-010 SHALL have port o_count  output  $clog2(DEPTH+1)  number of stored entries.
REQ-011 SHALL have port o_full  output  1  count == DEPTH.
REQ-012 SHALL have port o_empty  output  1  count == 0.
REQ-013 SHALL have port o_overflow  output  1  one-cycle pulse: software write dropped.

Function
REQ-014 SHALL treat a cycle with bit_field_if.valid=1 and write_mask!=0 as a push request; pushed entry = write_data & write_mask.
REQ-015 SHALL treat o_valid & i_ready as a pop; pop removes head at the same clock edge.
REQ-016 SHALL accept a push when count<DEPTH, or when count==DEPTH and a pop occurs in the same cycle.
REQ-017 SHALL drop a push otherwise and pulse o_overflow for exactly the following cycle; storage, pointers and count unchanged by the dropped push.
REQ-018 SHALL update count as +1 (push only), -1 (pop only), unchanged (both or neither).
REQ-019 SHALL present a pushed entry on o_valid/o_data one cycle after the push edge (no same-cycle fall-through), including when the FIFO was empty.
REQ-020 SHALL wrap read and write pointers from DEPTH-1 to 0.
REQ-021 SHALL hold o_data stable while o_valid=1 and no pop occurs; o_data SHALL be '0 when o_empty=1.
REQ-022 SHALL drive bit_field_if.read_data and bit_field_if.value with o_data (head peek); reads have no side effect.
REQ-023 SHALL, on i_clear=1, set count and both pointers to 0 at that edge, ignoring any push and pop in the same cycle, with no overflow pulse.
REQ-024 SHALL derive o_valid = !o_empty; o_full/o_empty SHALL be registered-consistent with o_count every cycle.
REQ-025 SHALL ignore read-only accesses (valid=1, write_mask=0) for FIFO state.

Reset
REQ-026 SHALL, while i_rst_n=0, force count=0, pointers=0, o_overflow=0, o_valid=0, o_empty=1, o_full=0, o_data='0.
REQ-027 SHALL NOT require storage array reset; empty-masking of o_data hides stale contents.
REQ-028 SHALL discard all entries when reset asserts mid-operation, and accept a push on the first edge after release.

Structure
REQ-029 SHALL take no new typedefs; count width SHALL be a localparam computed in the module, no shared-package addition needed.
REQ-030 SHALL use one sub-module rggen_fifo_ctrl (pointers, count, full/empty, overflow), with storage and bit_field_if mapping in the top.

Verification
REQ-031 SHALL cover: reset, write 0xA5 mask 0xFF -> o_valid=1 and o_data=0xA5 next cycle, o_count=1.
REQ-032 SHALL cover: write 0x3C with write_mask 0x0F -> entry 0x0C; read access with write_mask=0 -> count unchanged, read_data=head.
REQ-033 SHALL cover: DEPTH=4, 5 writes with i_ready=0 -> o_full=1, one o_overflow pulse, pops return first 4 values in order.
REQ-034 SHALL cover: full FIFO, push and pop same cycle -> push accepted, count stays 4, no overflow.
REQ-035 SHALL cover: 3 entries, i_clear with simultaneous push -> count=0, o_empty=1, o_data=0, no overflow.
REQ-036 SHALL cover: 2 entries, i_rst_n low mid-stream -> all outputs at reset values, next write visible one cycle later.
